// File: rtl/uart_led_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_led_pkg
// Brief  : Opcodes, reply codes and FSM encoding for the UART LED controller
// Rev    : 1.0
// ============================================================================
package uart_led_pkg;

    localparam logic [3:0] OP_TOGGLE    = 4'h0;
    localparam logic [3:0] OP_SET       = 4'h1;
    localparam logic [3:0] OP_CLEAR     = 4'h2;
    localparam logic [3:0] OP_BLINK_ON  = 4'h3;
    localparam logic [3:0] OP_BLINK_OFF = 4'h4;
    localparam logic [3:0] OP_READ      = 4'h5;
    localparam logic [3:0] OP_ALL_OFF   = 4'hF;

    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        REPLY = 2'd2
    } fsm_e;

endpackage
`default_nettype wire

// File: rtl/blink_prescaler.sv
`default_nettype none
// ============================================================================
// Module : blink_prescaler
// Brief  : Free-running divider producing the blink phase and its wrap tick
// Rev    : 1.0
// ============================================================================
module blink_prescaler #(
    parameter int CLK_HZ   = 50000000,
    parameter int BLINK_HZ = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic phase_o,
    output logic tick_o
);

    localparam int             HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int             CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0]  TERM = CW'(HALF - 1);

    logic [CW-1:0] cnt_q;
    logic          phase_q;

    // tick is combinational so the parent can see the next phase in the wrap cycle
    assign tick_o  = (cnt_q == TERM);
    assign phase_o = phase_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (tick_o) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q   <= cnt_q + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_led_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module : uart_led_cmd_ctrl
// Brief  : UART byte command decoder driving CH_NUM LEDs with ACK/NAK replies
// Rev    : 1.0
// ============================================================================
module uart_led_cmd_ctrl
    import uart_led_pkg::*;
#(
    parameter int CH_NUM   = 6,
    parameter int CLK_HZ   = 50000000,
    parameter int BLINK_HZ = 2,
    parameter int ACK_EN   = 1
) (
    input  logic              clk_50m,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic [CH_NUM-1:0] led,
    output logic              overflow,
    output logic              cmd_err
);

    localparam logic [CH_NUM-1:0] ONE_HOT0 = CH_NUM'(1);

    fsm_e              fsm_q;
    logic              rx_done_q;
    logic [7:0]        cmd_q;
    logic              pend_valid_q;
    logic [7:0]        pend_data_q;
    logic [CH_NUM-1:0] state_q, blink_q, led_q;
    logic [CH_NUM-1:0] state_d, blink_d, led_d;
    logic [7:0]        reply_q, tx_data_q;
    logic              tx_start_q, overflow_q, cmd_err_q;

    logic              w_phase, w_tick, w_phase_d, w_rx_edge;
    logic [3:0]        w_op, w_ch;
    logic [CH_NUM-1:0] w_sel, w_upd_state, w_upd_blink;
    logic [127:0]      w_ext;
    logic              w_ch_ok, w_rd_ok, w_cmd_ok, w_cmd_rd, w_reply_due;
    logic [7:0]        w_reply;

    blink_prescaler #(
        .CLK_HZ   (CLK_HZ),
        .BLINK_HZ (BLINK_HZ)
    ) u_prescaler (
        .clk_i   (clk_50m),
        .rst_i   (reset),
        .phase_o (w_phase),
        .tick_o  (w_tick)
    );

    assign w_phase_d = w_phase ^ w_tick;
    assign w_rx_edge = rx_done & ~rx_done_q;
    assign w_op      = cmd_q[7:4];
    assign w_ch      = cmd_q[3:0];
    assign w_sel     = ONE_HOT0 << w_ch;
    assign w_ext     = 128'(state_q);
    assign w_ch_ok   = {1'b0, w_ch} < 5'(CH_NUM);
    assign w_rd_ok   = {w_ch, 3'b000} < 7'(CH_NUM);

    always_comb begin
        w_upd_state = state_q;
        w_upd_blink = blink_q;
        w_cmd_ok    = 1'b0;
        w_cmd_rd    = 1'b0;
        case (w_op)
            OP_TOGGLE: if (w_ch_ok) begin
                w_cmd_ok    = 1'b1;
                w_upd_state = state_q ^ w_sel;
                w_upd_blink = blink_q & ~w_sel;
            end
            OP_SET: if (w_ch_ok) begin
                w_cmd_ok    = 1'b1;
                w_upd_state = state_q | w_sel;
                w_upd_blink = blink_q & ~w_sel;
            end
            OP_CLEAR: if (w_ch_ok) begin
                w_cmd_ok    = 1'b1;
                w_upd_state = state_q & ~w_sel;
                w_upd_blink = blink_q & ~w_sel;
            end
            OP_BLINK_ON: if (w_ch_ok) begin
                w_cmd_ok    = 1'b1;
                w_upd_blink = blink_q | w_sel;
            end
            OP_BLINK_OFF: if (w_ch_ok) begin
                w_cmd_ok    = 1'b1;
                w_upd_blink = blink_q & ~w_sel;
            end
            OP_READ: if (w_rd_ok) begin
                w_cmd_ok = 1'b1;
                w_cmd_rd = 1'b1;
            end
            OP_ALL_OFF: begin
                w_cmd_ok    = 1'b1;
                w_upd_state = '0;
                w_upd_blink = '0;
            end
            default: ;
        endcase

        w_reply_due = (ACK_EN != 0) || w_cmd_rd;
        if (!w_cmd_ok)
            w_reply = NAK_BYTE;
        else if (w_cmd_rd)
            w_reply = w_ext[{w_ch, 3'b000} +: 8];
        else
            w_reply = ACK_BYTE;

        state_d = (fsm_q == EXEC) ? w_upd_state : state_q;
        blink_d = (fsm_q == EXEC) ? w_upd_blink : blink_q;
        // next phase with next mask, so a wrap coinciding with an update is seen at once
        led_d   = (blink_d & {CH_NUM{w_phase_d}}) | (~blink_d & state_d);
    end

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            fsm_q        <= IDLE;
            rx_done_q    <= 1'b0;
            cmd_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            state_q      <= '0;
            blink_q      <= '0;
            led_q        <= '0;
            reply_q      <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            overflow_q   <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            rx_done_q  <= rx_done;
            state_q    <= state_d;
            blink_q    <= blink_d;
            led_q      <= led_d;
            tx_start_q <= 1'b0;
            cmd_err_q  <= 1'b0;

            if (fsm_q != IDLE && w_rx_edge) begin
                if (pend_valid_q) begin
                    overflow_q <= 1'b1;
                end else begin
                    pend_valid_q <= 1'b1;
                    pend_data_q  <= rx_data;
                end
            end

            case (fsm_q)
                IDLE: begin
                    if (pend_valid_q) begin
                        cmd_q <= pend_data_q;
                        fsm_q <= EXEC;
                        // a byte arriving while pending drains simply refills it
                        if (w_rx_edge)
                            pend_data_q <= rx_data;
                        else
                            pend_valid_q <= 1'b0;
                    end else if (w_rx_edge) begin
                        cmd_q <= rx_data;
                        fsm_q <= EXEC;
                    end
                end
                EXEC: begin
                    cmd_err_q <= ~w_cmd_ok;
                    reply_q   <= w_reply;
                    fsm_q     <= w_reply_due ? REPLY : IDLE;
                end
                REPLY: begin
                    if (!tx_busy) begin
                        tx_data_q  <= reply_q;
                        tx_start_q <= 1'b1;
                        fsm_q      <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign led      = led_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign overflow = overflow_q;
    assign cmd_err  = cmd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_led_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_led_cmd_ctrl
// Brief  : Directed self-checking bench for uart_led_cmd_ctrl (ACK_EN=1 and 0)
// Rev    : 1.0
// ============================================================================
module tb_uart_led_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00, rx_data2 = 8'h00;
    logic       rx_done = 1'b0, rx_done2 = 1'b0;
    logic       tx_busy = 1'b0, tx_busy2 = 1'b0;
    logic [7:0] tx_data, tx_data2;
    logic       tx_start, tx_start2;
    logic [5:0] led, led2;
    logic       overflow, overflow2, cmd_err, cmd_err2;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] tx_log[$];
    logic [7:0] tx_log2[$];
    int         err_total = 0, err_total2 = 0;

    always #5 clk = ~clk;

    uart_led_cmd_ctrl #(.CH_NUM(6), .CLK_HZ(40), .BLINK_HZ(2), .ACK_EN(1)) dut (
        .clk_50m(clk), .reset(rst), .rx_data(rx_data), .rx_done(rx_done),
        .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start), .led(led),
        .overflow(overflow), .cmd_err(cmd_err)
    );

    uart_led_cmd_ctrl #(.CH_NUM(6), .CLK_HZ(40), .BLINK_HZ(2), .ACK_EN(0)) dut2 (
        .clk_50m(clk), .reset(rst), .rx_data(rx_data2), .rx_done(rx_done2),
        .tx_busy(tx_busy2), .tx_data(tx_data2), .tx_start(tx_start2), .led(led2),
        .overflow(overflow2), .cmd_err(cmd_err2)
    );

    always @(negedge clk) begin
        if (tx_start)  tx_log.push_back(tx_data);
        if (tx_start2) tx_log2.push_back(tx_data2);
        if (cmd_err)   err_total++;
        if (cmd_err2)  err_total2++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send2(input logic [7:0] b);
        @(negedge clk);
        rx_data2 = b;
        rx_done2 = 1'b1;
        @(negedge clk);
        rx_done2 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (led !== 6'b0)     begin failures++; $display("FAIL reset_led: got %b want 000000", led); end
        checks++; if (tx_data !== 8'h0) begin failures++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (cmd_err !== 1'b0) begin failures++; $display("FAIL reset_cmd_err: got %b want 0", cmd_err); end
    endtask

    task automatic test_set_ack();
        int base;
        base = tx_log.size();
        send(8'h12);
        @(posedge clk); #1;
        checks++; if (led !== 6'b000100) begin failures++; $display("FAIL set_led_latency: got %b want 000100", led); end
        checks++; if (cmd_err !== 1'b0) begin failures++; $display("FAIL set_cmd_err: got %b want 0", cmd_err); end
        @(posedge clk); #1;
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h06) begin
            failures++; $display("FAIL set_tx_timing: got start=%b data=%h want start=1 data=06", tx_start, tx_data); end
        repeat (4) @(negedge clk);
        checks++; if (tx_log.size() - base != 1 || tx_log[base] !== 8'h06) begin
            failures++; $display("FAIL set_ack_count: got %0d replies want 1 of 06", tx_log.size() - base); end
    endtask

    task automatic test_read_nak();
        int base;
        int ebase;
        base = tx_log.size();
        send(8'h50);
        repeat (5) @(negedge clk);
        checks++; if (tx_log.size() - base != 1 || tx_log[base] !== 8'h04) begin
            failures++; $display("FAIL read_byte: got %0d replies last=%h want 1 of 04", tx_log.size() - base, tx_data); end
        base  = tx_log.size();
        ebase = err_total;
        send(8'h51);
        @(posedge clk); #1;
        checks++; if (cmd_err !== 1'b1) begin failures++; $display("FAIL nak_cmd_err_high: got %b want 1", cmd_err); end
        @(posedge clk); #1;
        checks++; if (cmd_err !== 1'b0) begin failures++; $display("FAIL nak_cmd_err_pulse: got %b want 0", cmd_err); end
        repeat (5) @(negedge clk);
        checks++; if (tx_log.size() - base != 1 || tx_log[base] !== 8'h15) begin
            failures++; $display("FAIL nak_reply: got %0d replies last=%h want 1 of 15", tx_log.size() - base, tx_data); end
        checks++; if (err_total - ebase != 1) begin failures++; $display("FAIL nak_err_count: got %0d want 1", err_total - ebase); end
        checks++; if (led !== 6'b000100) begin failures++; $display("FAIL nak_led_unchanged: got %b want 000100", led); end
    endtask

    task automatic test_blink();
        logic prev;
        int   cnt;
        bit   seen;
        int   bad;
        send(8'h33);
        @(negedge clk);
        prev = led[3];
        seen = 1'b0;
        for (int i = 0; i < 25 && !seen; i++) begin
            @(negedge clk);
            if (led[3] !== prev) seen = 1'b1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL blink_start: got no toggle in 25 cycles want toggle"); end
        for (int n = 0; n < 3; n++) begin
            prev = led[3];
            cnt  = 0;
            seen = 1'b0;
            for (int i = 0; i < 25 && !seen; i++) begin
                @(negedge clk);
                cnt++;
                if (led[3] !== prev) seen = 1'b1;
            end
            checks++; if (cnt != 10) begin failures++; $display("FAIL blink_period%0d: got %0d cycles want 10", n, cnt); end
        end
        checks++; if (led[2] !== 1'b1) begin failures++; $display("FAIL blink_other_ch: got %b want 1", led[2]); end
        send(8'h13);
        @(posedge clk); #1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (led !== 6'b001100) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL blink_cleared_steady: got %0d bad cycles (led=%b) want 0 (001100)", bad, led); end
    endtask

    task automatic test_back_to_back();
        int base;
        do_reset();
        tx_busy = 1'b1;
        base = tx_log.size();
        send(8'h00);
        send(8'h01);
        send(8'h02);
        repeat (44) @(negedge clk);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL b2b_overflow: got %b want 1", overflow); end
        checks++; if (led !== 6'b000001) begin failures++; $display("FAIL b2b_led_busy: got %b want 000001", led); end
        checks++; if (tx_log.size() != base) begin failures++; $display("FAIL b2b_no_tx_busy: got %0d want 0", tx_log.size() - base); end
        tx_busy = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (led !== 6'b000011) begin failures++; $display("FAIL b2b_led_final: got %b want 000011", led); end
        checks++; if (tx_log.size() - base != 2) begin failures++; $display("FAIL b2b_tx_count: got %0d want 2", tx_log.size() - base); end
        else begin
            checks++; if (tx_log[base] !== 8'h06 || tx_log[base+1] !== 8'h06) begin
                failures++; $display("FAIL b2b_tx_data: got %h %h want 06 06", tx_log[base], tx_log[base+1]); end
        end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL b2b_overflow_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_reset_in_reply();
        int base;
        do_reset();
        tx_busy = 1'b1;
        send(8'h00);
        repeat (3) @(negedge clk);
        checks++; if (led !== 6'b000001) begin failures++; $display("FAIL rr_led_before: got %b want 000001", led); end
        rst = 1'b1;
        #1;
        checks++; if (led !== 6'b0 || tx_data !== 8'h0 || tx_start !== 1'b0 || overflow !== 1'b0 || cmd_err !== 1'b0) begin
            failures++; $display("FAIL rr_async_clear: got led=%b data=%h start=%b ovf=%b err=%b want all 0",
                                 led, tx_data, tx_start, overflow, cmd_err); end
        base = tx_log.size();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tx_busy = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (tx_log.size() != base) begin failures++; $display("FAIL rr_no_tx_after_reset: got %0d want 0", tx_log.size() - base); end
        send(8'hF0);
        repeat (5) @(negedge clk);
        checks++; if (led !== 6'b0) begin failures++; $display("FAIL rr_all_off_led: got %b want 000000", led); end
        checks++; if (tx_log.size() - base != 1 || tx_data !== 8'h06) begin
            failures++; $display("FAIL rr_all_off_ack: got %0d replies data=%h want 1 of 06", tx_log.size() - base, tx_data); end
    endtask

    task automatic test_ack_disabled();
        send2(8'h10);
        repeat (6) @(negedge clk);
        send2(8'h70);
        repeat (6) @(negedge clk);
        send2(8'h50);
        repeat (6) @(negedge clk);
        checks++; if (tx_log2.size() != 1) begin failures++; $display("FAIL noack_tx_count: got %0d want 1", tx_log2.size()); end
        else begin
            checks++; if (tx_log2[0] !== 8'h01) begin failures++; $display("FAIL noack_read_data: got %h want 01", tx_log2[0]); end
        end
        checks++; if (err_total2 != 1) begin failures++; $display("FAIL noack_cmd_err: got %0d want 1", err_total2); end
        checks++; if (led2 !== 6'b000001) begin failures++; $display("FAIL noack_led: got %b want 000001", led2); end
    endtask

    initial begin
        test_reset();
        test_set_ack();
        test_read_nak();
        test_blink();
        test_back_to_back();
        test_reset_in_reply();
        test_ack_disabled();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_led_cmd_ctrl.md
Name: uart_led_cmd_ctrl

Overview:
UART-command-driven LED/GPIO controller for CH_NUM channels. It takes received bytes from the UART RX path and decodes each one as opcode plus channel. It supports set, clear, toggle, blink and readback, and returns an ACK, NAK or status byte through the UART TX path using a busy handshake. It sits in top between the UART RX/TX paths and the LED pins, and replaces the fixed 6-bit toggle-only LED logic; opcode 0 keeps the old 0x00..0x05 toggle encoding.

Parameters:
CH_NUM, 6, number of channels, 1..16
CLK_HZ, 50000000, clk_50m frequency in Hz
BLINK_HZ, 2, blink frequency in Hz; phase toggles every CLK_HZ/(2*BLINK_HZ) cycles
ACK_EN, 1, 1 = reply to every command; 0 = reply only to READ

Ports:
clk_50m  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_data  in  8  received byte; valid while rx_done is high
rx_done  in  1  RX byte-complete, synchronous to clk_50m; its rising edge is detected internally
tx_busy  in  1  UART TX busy; high means no new byte may be started
tx_data  out  8  reply byte; held stable from tx_start until the next reply
tx_start  out  1  one-cycle pulse that starts a TX byte
led  out  CH_NUM  channel outputs
overflow  out  1  sticky flag: a command byte was dropped
cmd_err  out  1  one-cycle pulse on an invalid command

Behaviour:
- Reset values: led=0, tx_data=0, tx_start=0, overflow=0, cmd_err=0. Internal state cleared: state=0, blink mask=0, prescaler=0, phase=0, pending buffer empty, FSM=IDLE.
- Reset asserted mid-operation aborts everything immediately. No tx_start is issued after reset, and the pending byte is discarded.
- Command byte format: opcode=[7:4], channel=[3:0].
- Opcodes:
  - 0 TOGGLE
  - 1 SET
  - 2 CLEAR
  - 3 BLINK_ON
  - 4 BLINK_OFF
  - 5 READ
  - F ALL_OFF (channel field ignored)
  - any other opcode is invalid
- Channel rules: for opcodes 0-4, a channel >= CH_NUM is invalid. For READ, channel n selects state bits [8n+7:8n], zero-extended. READ is invalid if 8n >= CH_NUM.
- Update rules:
  - TOGGLE, SET and CLEAR modify state[ch] and clear blink[ch].
  - BLINK_ON sets blink[ch]. BLINK_OFF clears blink[ch]. Neither changes state[ch].
  - ALL_OFF clears state and blink.
  - An invalid command changes nothing and pulses cmd_err for one cycle.
- Output mapping: led[i] = blink[i] ? phase : state[i], registered.
- Prescaler: counts 0..CLK_HZ/(2*BLINK_HZ)-1. At terminal count it wraps to 0 and toggles phase. It free-runs, independent of commands.
- Reply bytes:
  - valid write -> 0x06 (ACK)
  - invalid command -> 0x15 (NAK)
  - READ -> the selected state byte
  - with ACK_EN=0, only a valid READ replies; NAK is also suppressed.
- FSM states:
  - IDLE: a rising edge of rx_done, or a non-empty pending buffer (pending has priority), moves to EXEC. The byte is captured at edge k.
  - EXEC: at edge k+1, apply the update, register led and cmd_err, and select the reply. Go to REPLY if a reply is due, else IDLE.
  - REPLY: wait while tx_busy=1. At the first edge with tx_busy=0, drive tx_data and tx_start=1 for exactly one cycle, then go to IDLE.
- Latency: led changes 2 edges after the rx_done rising edge. The earliest tx_start is asserted in the cycle after edge k+2.
- Pending buffer (1 deep):
  - An rx_done edge outside IDLE stores the byte into pending.
  - An rx_done edge while pending is full drops the byte and sets overflow (sticky until reset).
  - Pending is consumed on the IDLE cycle after returning.
- Simultaneous events: an rx_done edge in the same cycle pending is consumed in IDLE goes into pending and does not overflow. A prescaler wrap in the same cycle as a blink update uses the new phase together with the new mask.

Decomposition:
- Shared include/package uart_led_pkg holds:
  - opcode constants OP_TOGGLE..OP_ALL_OFF
  - reply codes ACK_BYTE=8'h06 and NAK_BYTE=8'h15
  - FSM state encodings IDLE, EXEC, REPLY
- One sub-module, blink_prescaler, with parameters CLK_HZ and BLINK_HZ and outputs phase and tick.
- The FSM, pending buffer and channel registers stay in the parent module.

Test Plan:
- Reset, then rx byte 0x12 with tx_busy=0 -> led=6'b000100 two edges later; tx_start pulse with tx_data=0x06; cmd_err=0.
- After 0x12, send 0x50 -> tx_data=0x04. Send 0x51 with CH_NUM=6 -> tx_data=0x15, cmd_err pulse, led unchanged.
- Sim CLK_HZ=40, BLINK_HZ=2: send 0x33 -> led[3] toggles every 10 cycles. Then send 0x13 -> led[3]=1 steady and blink cleared.
- Hold tx_busy=1 for 50 cycles, then send 0x00, 0x01, 0x02 back-to-back -> first byte executed, second pending, third dropped, overflow=1. After tx_busy falls: led=6'b000011, exactly 2 tx_start pulses, each 0x06.
- Send 0x00, then assert reset while in REPLY -> all outputs 0 and no tx_start afterwards. Then send 0xF0 -> led=0, ACK 0x06.
- ACK_EN=0: send 0x10, 0x70, 0x50 -> only one tx_start (0x01); cmd_err pulses once, for 0x70.
